// File: rtl/cnn_mem_pkg.sv
// Shared definitions for CNN line/feature buffer memories built on
// two-port 1W1R register-file macros.
package cnn_mem_pkg;

    // Macro chip enables are active low
    localparam logic SRAM_CEN_ON  = 1'b0;
    localparam logic SRAM_CEN_OFF = 1'b1;

    // Cycles from the edge that samples CENA=0 until QA holds the word
    localparam int SRAM_RD_LAT = 1;

    // Output buffering needed to hide the read latency at full rate
    localparam int SKID_ENTRIES = SRAM_RD_LAT + 1;

    // Pointer advance with wrap for depths that are not a power of two
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Valid/ready word stream used on both sides of the SRAM FIFO controller.
interface sram_fifo_ctrl_if #(
    parameter int WIDTH = 96
) ();

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/fifo_skid2.sv
// Two-entry in-order buffer that catches words returning from the macro
// read port and presents the oldest one as the FIFO head.
module fifo_skid2 #(
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             capture,
    input  logic [WIDTH-1:0] cap_data,
    input  logic             pop,
    output logic [1:0]       buf_cnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             pop_ok;

    assign pop_ok    = pop && (buf_cnt != 2'd0);
    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = head;

    // Capture lands behind any held word; a pop shifts the tail forward
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_cnt <= 2'd0;
            head    <= '0;
            tail    <= '0;
        end else if (clr) begin
            buf_cnt <= 2'd0;
        end else begin
            case ({capture, pop_ok})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        head <= cap_data;
                    end else begin
                        tail <= cap_data;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    head    <= tail;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        head <= cap_data;
                    end else begin
                        head <= tail;
                        tail <= cap_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO controller driving one external 1W1R register-file
// macro. The macro's one-cycle read latency is hidden by a two-entry
// output buffer so one push and one pop can happen every cycle.
module sram_fifo_ctrl
    import cnn_mem_pkg::*;
#(
    parameter  int WIDTH = 96,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 3)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    sram_fifo_ctrl_if.slave  in_if,
    sram_fifo_ctrl_if.master out_if,
    output logic [CW-1:0]    count,
    output logic             sram_cenb,
    output logic [AW-1:0]    sram_ab,
    output logic [WIDTH-1:0] sram_db,
    output logic             sram_cena,
    output logic [AW-1:0]    sram_aa,
    input  logic [WIDTH-1:0] sram_qa
);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] sram_cnt;
    logic          inflight;
    logic [1:0]    buf_cnt;
    logic          buf_valid;
    logic          in_ready;
    logic          push;
    logic          pop;
    logic          rd;
    logic [2:0]    occ_next;

    // Ready is held low during reset and flush so no write can sneak in
    assign in_ready = rstn && !clr && (sram_cnt < CW'(DEPTH));
    assign push     = in_if.valid && in_ready;
    assign pop      = buf_valid && out_if.ready;

    // Issue a read only if the word will still have a buffer slot when it returns
    assign occ_next = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
    assign rd       = (sram_cnt != '0) && (occ_next < 3'(SKID_ENTRIES)) && !clr;

    assign in_if.ready = in_ready;
    assign sram_cenb   = push ? SRAM_CEN_ON : SRAM_CEN_OFF;
    assign sram_ab     = wptr;
    assign sram_db     = in_if.data;
    assign sram_cena   = rd ? SRAM_CEN_ON : SRAM_CEN_OFF;
    assign sram_aa     = rptr;

    assign count = sram_cnt + CW'(inflight) + CW'(buf_cnt);

    // Pointer, occupancy and in-flight tracking for the macro ports
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            sram_cnt <= '0;
            inflight <= 1'b0;
        end else if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            sram_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            if (push) begin
                wptr <= AW'(ptr_inc(32'(wptr), DEPTH));
            end
            if (rd) begin
                rptr <= AW'(ptr_inc(32'(rptr), DEPTH));
            end
            sram_cnt <= sram_cnt + CW'(push) - CW'(rd);
            inflight <= rd;
        end
    end

    fifo_skid2 #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .capture  (inflight),
        .cap_data (sram_qa),
        .pop      (pop),
        .buf_cnt  (buf_cnt),
        .out_valid(buf_valid),
        .out_data (out_if.data)
    );

    assign out_if.valid = buf_valid;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Scoreboard bench for sram_fifo_ctrl: a 256-deep instance exercises the
// directed cases and a 100-deep instance exercises non-power-of-two wrap.
module tb_sram_fifo_ctrl;

    localparam int W    = 96;
    localparam int DA   = 256;
    localparam int DB   = 100;
    localparam int AWA  = $clog2(DA);
    localparam int AWB  = $clog2(DB);
    localparam int CWA  = $clog2(DA + 3);
    localparam int CWB  = $clog2(DB + 3);

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic a_clr = 1'b0;
    logic b_clr = 1'b0;

    sram_fifo_ctrl_if #(.WIDTH(W)) a_in ();
    sram_fifo_ctrl_if #(.WIDTH(W)) a_out ();
    sram_fifo_ctrl_if #(.WIDTH(W)) b_in ();
    sram_fifo_ctrl_if #(.WIDTH(W)) b_out ();

    logic [CWA-1:0] a_count;
    logic           a_cenb, a_cena;
    logic [AWA-1:0] a_ab, a_aa;
    logic [W-1:0]   a_db, a_qa;
    logic [CWB-1:0] b_count;
    logic           b_cenb, b_cena;
    logic [AWB-1:0] b_ab, b_aa;
    logic [W-1:0]   b_db, b_qa;

    logic [W-1:0] mem_a [DA];
    logic [W-1:0] mem_b [DB];

    logic [W-1:0] q_a [$];
    logic [W-1:0] q_b [$];

    int n_vectors = 0;
    int n_miscompares = 0;
    int pop_a = 0;
    int pop_b = 0;

    sram_fifo_ctrl #(.WIDTH(W), .DEPTH(DA)) dut_a (
        .clk(clk), .rstn(rstn), .clr(a_clr),
        .in_if(a_in), .out_if(a_out), .count(a_count),
        .sram_cenb(a_cenb), .sram_ab(a_ab), .sram_db(a_db),
        .sram_cena(a_cena), .sram_aa(a_aa), .sram_qa(a_qa)
    );

    sram_fifo_ctrl #(.WIDTH(W), .DEPTH(DB)) dut_b (
        .clk(clk), .rstn(rstn), .clr(b_clr),
        .in_if(b_in), .out_if(b_out), .count(b_count),
        .sram_cenb(b_cenb), .sram_ab(b_ab), .sram_db(b_db),
        .sram_cena(b_cena), .sram_aa(b_aa), .sram_qa(b_qa)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Behavioural model of the 256-word macro
    always @(posedge clk) begin
        if (a_cenb == 1'b0) mem_a[a_ab] <= a_db;
        if (a_cena == 1'b0) a_qa <= mem_a[a_aa];
    end

    // Behavioural model of the 100-word macro
    always @(posedge clk) begin
        if (b_cenb == 1'b0) mem_b[b_ab] <= b_db;
        if (b_cena == 1'b0) b_qa <= mem_b[b_aa];
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic r, input logic c);
        @(posedge clk);
        #1;
        a_in.valid  = v;
        a_in.data   = d;
        a_out.ready = r;
        a_clr       = c;
        #1;
    endtask

    // Scoreboard for instance A: compare pops, then record accepted pushes
    always @(negedge clk) begin
        if (!rstn || a_clr) begin
            q_a.delete();
        end else begin
            if (a_out.valid && a_out.ready) begin
                pop_a++;
                if (q_a.size() == 0) begin
                    n_vectors++;
                    n_miscompares++;
                    $display("[TB] FAIL a_unexpected_pop: got 0x%0h, expected no output", a_out.data);
                end else begin
                    checkOutput("a_pop_data", a_out.data, q_a.pop_front());
                end
            end
            if (a_in.valid && a_in.ready) q_a.push_back(a_in.data);
        end
    end

    // Scoreboard for instance B
    always @(negedge clk) begin
        if (!rstn) begin
            q_b.delete();
        end else begin
            if (b_out.valid && b_out.ready) begin
                pop_b++;
                if (q_b.size() == 0) begin
                    n_vectors++;
                    n_miscompares++;
                    $display("[TB] FAIL b_unexpected_pop: got 0x%0h, expected no output", b_out.data);
                end else begin
                    checkOutput("b_pop_data", b_out.data, q_b.pop_front());
                end
            end
            if (b_in.valid && b_in.ready) q_b.push_back(b_in.data);
        end
    end

    // Hard stop in case the sequence below ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int pushed;
        int cyc;
        int bubbles;
        int max_cnt;
        int seen;
        int pop0;

        a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
        b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;

        // Reset state, with a push request present to prove it is blocked
        repeat (3) @(posedge clk);
        #1 a_in.valid = 1'b1;
        #1;
        checkOutput("rst_cenb", a_cenb, 1);
        checkOutput("rst_cena", a_cena, 1);
        checkOutput("rst_out_valid", a_out.valid, 0);
        checkOutput("rst_count", a_count, 0);
        a_in.valid = 1'b0;
        @(posedge clk);
        #3 rstn = 1'b1;
        #1 checkOutput("rel_in_ready", a_in.ready, 1);

        // Single push of 0xA5: write, read issue, then output two cycles later
        applyStimulus(1, 'hA5, 1, 0);
        checkOutput("t1_cenb", a_cenb, 0);
        checkOutput("t1_ab", a_ab, 0);
        checkOutput("t1_count0", a_count, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t1_cena", a_cena, 0);
        checkOutput("t1_aa", a_aa, 0);
        checkOutput("t1_count1", a_count, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t1_count2", a_count, 1);
        checkOutput("t1_not_yet_valid", a_out.valid, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t1_out_valid", a_out.valid, 1);
        checkOutput("t1_out_data", a_out.data, 'hA5);
        checkOutput("t1_count3", a_count, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t1_count4", a_count, 0);
        checkOutput("t1_empty", a_out.valid, 0);

        // Continuous push and pop of 1000 incrementing words
        pushed = 0; cyc = 0; bubbles = 0; max_cnt = 0; seen = 0;
        for (int k = 0; k < 1200 && pushed < 1000; k++) begin
            applyStimulus(1, W'(pushed), 1, 0);
            cyc++;
            if (a_in.ready) pushed++;
            if (a_out.valid) seen = 1;
            else if (seen != 0) bubbles++;
            if (int'(a_count) > max_cnt) max_cnt = int'(a_count);
        end
        for (int k = 0; k < 20 && q_a.size() != 0; k++) begin
            applyStimulus(0, 0, 1, 0);
            if (q_a.size() != 0 && !a_out.valid) bubbles++;
            if (int'(a_count) > max_cnt) max_cnt = int'(a_count);
        end
        checkOutput("stream_cycles", cyc, 1000);
        checkOutput("stream_drained", q_a.size(), 0);
        checkOutput("stream_no_bubble", bubbles, 0);
        checkOutput("stream_count_le3", (max_cnt <= 3), 1);

        // Fill with the output stalled until the write port closes
        pushed = 0;
        for (int k = 0; k < 400; k++) begin
            applyStimulus(1, W'(pushed), 0, 0);
            if (!a_in.ready) break;
            pushed++;
        end
        checkOutput("fill_pushed", pushed, 258);
        checkOutput("fill_count", a_count, 258);
        checkOutput("fill_out_valid", a_out.valid, 1);
        checkOutput("fill_head", a_out.data, 0);
        checkOutput("fill_cena_idle", a_cena, 1);
        checkOutput("fill_cenb_idle", a_cenb, 1);
        pop0 = pop_a;
        for (int k = 0; k < 300 && q_a.size() != 0; k++) applyStimulus(0, 0, 1, 0);
        checkOutput("fill_drained", q_a.size(), 0);
        checkOutput("fill_pop_total", pop_a - pop0, 258);
        applyStimulus(0, 0, 1, 0);
        checkOutput("fill_empty_count", a_count, 0);

        // Depth-100 instance with random push/pop interleave, 250 words
        pushed = 0;
        for (int k = 0; k < 4000 && pop_b < 250; k++) begin
            @(posedge clk);
            #1;
            b_in.valid  = (pushed < 250) && ($urandom_range(0, 3) != 0);
            b_in.data   = W'(pushed);
            b_out.ready = ($urandom_range(0, 2) != 0);
            #1;
            if (b_in.valid && b_in.ready) pushed++;
        end
        b_in.valid = 1'b0;
        b_out.ready = 1'b0;
        checkOutput("b_pushed", pushed, 250);
        checkOutput("b_popped", pop_b, 250);
        @(posedge clk);
        #2 checkOutput("b_empty_count", b_count, 0);

        // Flush while a read is in flight and five words are held
        for (int j = 0; j < 6; j++) applyStimulus(1, W'('h200 + j), 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("clr_pre_rd_issue", a_cena, 0);
        applyStimulus(1, 'h999, 1, 1);
        checkOutput("clr_held", a_count, 5);
        checkOutput("clr_in_ready", a_in.ready, 0);
        checkOutput("clr_cena", a_cena, 1);
        checkOutput("clr_cenb", a_cenb, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("clr_count", a_count, 0);
        checkOutput("clr_out_valid", a_out.valid, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput("clr_no_ghost", a_out.valid, 0);
        end
        pop0 = pop_a;
        applyStimulus(1, 'h7, 1, 0);
        for (int k = 0; k < 10 && pop_a == pop0; k++) applyStimulus(0, 0, 1, 0);
        checkOutput("clr_after_push_pop", pop_a - pop0, 1);

        // Asynchronous reset in the middle of a stream
        for (int k = 0; k < 8; k++) applyStimulus(1, W'('h300 + k), 1, 0);
        #1 rstn = 1'b0;
        #1;
        checkOutput("arst_out_valid", a_out.valid, 0);
        checkOutput("arst_count", a_count, 0);
        checkOutput("arst_cena", a_cena, 1);
        checkOutput("arst_cenb", a_cenb, 1);
        a_in.valid = 1'b0;
        a_out.ready = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        #1;
        checkOutput("arst_rel_count", a_count, 0);
        checkOutput("arst_rel_in_ready", a_in.ready, 1);
        pop0 = pop_a;
        for (int k = 0; k < 3; k++) applyStimulus(1, W'('h400 + k), 1, 0);
        for (int k = 0; k < 10 && q_a.size() != 0; k++) applyStimulus(0, 0, 1, 0);
        checkOutput("arst_after_pops", pop_a - pop0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Valid/ready FIFO controller that drives one external two-port 1W1R register-file macro (rfdpDEPTHxWIDTH).
- Sits directly upstream of the macro. Generates write-port signals (CENB/AB/DB) and read-port signals (CENA/AA), and consumes QA.
- Hides the 1-cycle read latency behind a 2-entry output buffer, so it sustains one push and one pop per cycle.
- Used for line/feature buffers between CNN pipeline stages.

Parameters:
- WIDTH, 96, data word width; equals the macro width.
- DEPTH, 256, macro word count; need not be a power of two.
- AW, $clog2(DEPTH), macro address width; derived, not overridden.
- CW, $clog2(DEPTH+3), width of count.

Ports:
- clk  in  1  single clock; also drives macro CLKA and CLKB.
- rstn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush.
- in_valid  in  1  push request.
- in_ready  out  1  push accepted when in_valid && in_ready.
- in_data  in  WIDTH  push data.
- out_valid  out  1  head word available.
- out_ready  in  1  pop when out_valid && out_ready.
- out_data  out  WIDTH  head word.
- count  out  CW  total words held (SRAM + in-flight read + output buffer).
- sram_cenb  out  1  macro write enable, active low.
- sram_ab  out  AW  macro write address.
- sram_db  out  WIDTH  macro write data.
- sram_cena  out  1  macro read enable, active low.
- sram_aa  out  AW  macro read address.
- sram_qa  in  WIDTH  macro read data; valid the cycle after the edge that sampled cena=0.

Behaviour:
- Reset (rstn=0, async): wptr=rptr=0, sram_cnt=0, inflight=0, buffer empty. Outputs: out_valid=0, count=0, sram_cena=1, sram_cenb=1. in_ready=1 once rstn is released.
- in_ready = !clr && (sram_cnt < DEPTH). Combinational; does not depend on in_valid.
- Write:
  - push = in_valid && in_ready.
  - sram_cenb = !push, sram_ab = wptr, sram_db = in_data, all combinational. The macro captures on the clk edge.
  - wptr increments on push and wraps DEPTH-1 -> 0.
- Read issue:
  - pop = out_valid && out_ready.
  - rd = (sram_cnt > 0) && (buf_cnt + inflight - pop < 2) && !clr.
  - sram_cena = !rd, sram_aa = rptr. rptr increments and wraps like wptr.
  - inflight <= rd.
- sram_cnt update: next = sram_cnt + push - rd.
  - A word written at edge E is first readable from the cycle after E. There is no same-cycle bypass, so no read-during-write hazard.
- Output buffer (2 entries, in order):
  - When inflight=1, sram_qa is captured at the next edge.
  - out_valid = buf_cnt > 0; out_data = head entry (registered).
  - Capture and pop in the same cycle are allowed.
  - The rd condition guarantees the buffer never overflows.
- Latency: a word pushed at edge E0 into an empty FIFO is read-issued in the cycle after E0, captured at E2, and shown with out_valid=1 after E2. That is 2 cycles from push edge to out_valid.
- Throughput: with both sides always active, one push and one pop per cycle once out_valid rises.
- count = sram_cnt + inflight + buf_cnt. Maximum DEPTH+2 (SRAM full and buffer full).
- Full: sram_cnt == DEPTH forces in_ready=0. A simultaneous rd does not re-open the port in that cycle.
- Empty: no rd issued, and out_valid drops after the last pop.
- clr:
  - Next edge: pointers, sram_cnt, inflight and buffer go to 0.
  - In the clr cycle, in_ready=0, sram_cena=1, sram_cenb=1.
  - A read already in flight is discarded, not captured.
  - Any pop in the clr cycle is ignored.
- Reset mid-operation: immediate return to reset state. Macro contents are don't-care.
- out_data holds its value while out_valid && !out_ready. It is X/stale when out_valid=0; the bench must not check it then.

Decomposition:
- Shared package cnn_mem_pkg holds:
  - SRAM_CEN_ON = 1'b0, SRAM_CEN_OFF = 1'b1
  - SRAM_RD_LAT = 1
  - function ptr_inc(ptr, depth) for non-power-of-2 wrap
- One sub-module: fifo_skid2 (2-entry in-order output buffer with capture/pop/clear inputs, buf_cnt output).

Test Plan:
- Reset release, then push 0xA5 once with out_ready=1 -> sram_cenb=0 with ab=0 on the push cycle; cena=0 with aa=0 the next cycle; out_valid=1 with out_data=0xA5 two cycles after the push edge; count goes 1,1,1,0.
- Continuous push and pop of 1000 incrementing words, DEPTH=256 -> no bubble after the first out_valid; data in order; count stays ≤ 3.
- Fill with out_ready=0 -> in_ready falls exactly when 258 words are held (count=258); buffer holds words 0,1; pop all -> 0..257 in order; pointers wrap correctly.
- DEPTH=100: push 250 and pop 250 interleaved randomly -> wrap 99->0 is correct and no data loss.
- clr asserted the cycle after a read issue, with 5 words held -> the next cycle has count=0, out_valid=0, and the in-flight word is never presented; a subsequent push 0x7 returns 0x7.
- rstn pulsed low mid-stream -> all outputs take reset values asynchronously; the FIFO is empty and functional after release.
